// File: rtl/dmem_pkg.sv
// Shared constants and payload types for the data-memory port A arbiter.
package dmem_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DMEM_ADDR_LSB = 2;
    localparam int unsigned DMEM_ADDR_MSB = 11;
    localparam int unsigned NUM_CORES_DEF = 4;
    localparam int unsigned LOCK_CNT_W    = 4;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Word address the BRAM actually decodes from a byte address
    function automatic logic [DMEM_ADDR_MSB-DMEM_ADDR_LSB:0] word_index(input logic [WORD_W-1:0] byte_addr);
        return byte_addr[DMEM_ADDR_MSB:DMEM_ADDR_LSB];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first eligible requester at or after start, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    logic [N-1:0] elig;

    assign elig = req & ~excl;

    always_comb begin
        int unsigned c;
        idx_c   = '0;
        valid_c = 1'b0;
        c       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(start) + k) % N;
            if (!valid_c && elig[IW'(c)]) begin
                valid_c = 1'b1;
                idx_c   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock sharing data-memory port A among cores;
// issues one access per cycle and returns registered load data one cycle later.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned IDX_W     = $clog2(NUM_CORES),
    parameter int unsigned MAX_LOCK  = 4
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [NUM_CORES-1:0]        Req,
    input  logic [NUM_CORES-1:0]        Req_Write,
    input  logic [NUM_CORES-1:0]        Req_Lock,
    input  logic [NUM_CORES*WORD_W-1:0] Req_Address,
    input  logic [NUM_CORES*WORD_W-1:0] Req_WriteData,
    output logic [NUM_CORES-1:0]        Ack,
    output logic [NUM_CORES-1:0]        Rsp_Valid,
    output logic [WORD_W-1:0]           Rsp_ReadData,
    output logic [WORD_W-1:0]           Mem_Address,
    output logic [WORD_W-1:0]           Mem_WriteData,
    output logic                        Mem_MemWrite,
    output logic                        Mem_MemRead,
    input  logic [WORD_W-1:0]           Mem_ReadData,
    output logic [IDX_W-1:0]            Grant_Idx
);

    localparam int unsigned CNT_W = LOCK_CNT_W;

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]     lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [NUM_CORES-1:0] rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]    rsp_data_q, rsp_data_d;
    mem_req_t             last_q, last_d;
    logic [IDX_W-1:0]     grant_q, grant_d;

    logic                 owner_req, lock_hit, forced;
    logic                 pick_vld, win_vld, issue, win_write;
    logic [IDX_W-1:0]     pick_idx, win_idx;
    logic [NUM_CORES-1:0] excl, win_oh;
    mem_req_t             win_req;

    // Owner keeps priority until MAX_LOCK grants, then sits out one arbitration
    assign owner_req = Req[lock_owner_q];
    assign lock_hit  = lock_vld_q && owner_req && (lock_cnt_q < CNT_W'(MAX_LOCK));
    assign forced    = lock_vld_q && (lock_cnt_q >= CNT_W'(MAX_LOCK));
    assign excl      = forced ? (NUM_CORES'(1) << lock_owner_q) : '0;

    rr_pick #(
        .N  (NUM_CORES),
        .IW (IDX_W)
    ) u_pick (
        .req     (Req),
        .start   (rr_ptr_q),
        .excl    (excl),
        .idx_c   (pick_idx),
        .valid_c (pick_vld)
    );

    // A forced-out owner may still win if nobody else is asking
    always_comb begin
        win_idx = pick_idx;
        win_vld = pick_vld;
        if (lock_hit) begin
            win_idx = lock_owner_q;
            win_vld = 1'b1;
        end else if (!pick_vld && forced && owner_req) begin
            win_idx = lock_owner_q;
            win_vld = 1'b1;
        end
        issue         = win_vld && Rst_n;
        win_oh        = NUM_CORES'(1) << win_idx;
        win_write     = Req_Write[win_idx];
        win_req.addr  = Req_Address[WORD_W*win_idx +: WORD_W];
        win_req.wdata = Req_WriteData[WORD_W*win_idx +: WORD_W];
    end

    assign Ack           = issue ? win_oh : '0;
    assign Mem_MemWrite  = issue && win_write;
    assign Mem_MemRead   = issue && !win_write;
    assign Mem_Address   = issue ? win_req.addr : last_q.addr;
    assign Mem_WriteData = issue ? win_req.wdata : last_q.wdata;
    assign Grant_Idx     = issue ? win_idx : grant_q;
    assign Rsp_Valid     = rsp_valid_q;
    assign Rsp_ReadData  = rsp_data_q;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_vld_d   = lock_vld_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        last_d       = last_q;
        grant_d      = grant_q;

        if (lock_vld_q && !owner_req) begin
            lock_vld_d = 1'b0;
            lock_cnt_d = '0;
        end

        if (issue) begin
            rr_ptr_d = (32'(win_idx) == NUM_CORES - 1) ? '0 : win_idx + IDX_W'(1);
            last_d   = win_req;
            grant_d  = win_idx;
            if (Req_Lock[win_idx]) begin
                lock_vld_d   = 1'b1;
                lock_owner_d = win_idx;
                lock_cnt_d   = lock_hit ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = '0;
            end
            if (!win_write) begin
                rsp_valid_d = win_oh;
                rsp_data_d  = Mem_ReadData;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_ptr_q     <= '0;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            last_q       <= '0;
            grant_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-core request queues, a negedge-clocked
// data memory, and a monitor that matches every grant and load response.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned IW = 2;

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic [NC-1:0]        Req, Req_Write, Req_Lock, Ack, Rsp_Valid;
    logic [NC*WORD_W-1:0] Req_Address, Req_WriteData;
    logic [WORD_W-1:0]    Rsp_ReadData, Mem_Address, Mem_WriteData, Mem_ReadData;
    logic                 Mem_MemWrite, Mem_MemRead;
    logic [IW-1:0]        Grant_Idx;

    typedef struct {
        int          core;
        bit          wr;
        bit          lk;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          core;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } iss_t;

    txn_t        cq[NC][$];
    iss_t        exp_iss[$];
    logic [31:0] mem [1024];
    logic [NC-1:0] ack_seen = '0;
    bit          due = 1'b0;
    int          due_core = 0;
    logic [31:0] due_data = '0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter u_dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Req           (Req),
        .Req_Write     (Req_Write),
        .Req_Lock      (Req_Lock),
        .Req_Address   (Req_Address),
        .Req_WriteData (Req_WriteData),
        .Ack           (Ack),
        .Rsp_Valid     (Rsp_Valid),
        .Rsp_ReadData  (Rsp_ReadData),
        .Mem_Address   (Mem_Address),
        .Mem_WriteData (Mem_WriteData),
        .Mem_MemWrite  (Mem_MemWrite),
        .Mem_MemRead   (Mem_MemRead),
        .Mem_ReadData  (Mem_ReadData),
        .Grant_Idx     (Grant_Idx)
    );

    function automatic logic [31:0] init_word(input int k);
        return 32'h5A00_0000 | 32'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input int core, input bit wr, input bit lk,
                            input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.core = core; t.wr = wr; t.lk = lk; t.addr = addr; t.wdata = wdata;
        cq[core].push_back(t);
    endtask

    task automatic exp_i(input int core, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        iss_t e;
        e.core = core; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        exp_iss.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        bit busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 60) begin
            @(negedge Clk);
            n++;
            busy = due || (exp_iss.size() != 0);
            for (int i = 0; i < NC; i++) busy = busy || (cq[i].size() != 0);
        end
        n_chk++;
        if (busy) begin
            n_err++;
            $display("FAIL drain_timeout: %0d grants still pending after %0d cycles, required 0", exp_iss.size(), n);
        end
    endtask

    // Data memory port A: clocked on the falling edge
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = init_word(k);
        mem[4] = 32'hDEAD_BEEF;
        Mem_ReadData = '0;
        forever begin
            @(negedge Clk);
            if (Mem_MemWrite) mem[word_index(Mem_Address)] = Mem_WriteData;
            Mem_ReadData <= mem[word_index(Mem_Address)];
        end
    end

    // Core models: hold the head request until Ack was seen, then advance
    initial begin
        Req = '0; Req_Write = '0; Req_Lock = '0; Req_Address = '0; Req_WriteData = '0;
        forever begin
            @(posedge Clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (ack_seen[i] && cq[i].size() != 0) void'(cq[i].pop_front());
                if (cq[i].size() != 0) begin
                    Req[i]       = 1'b1;
                    Req_Write[i] = cq[i][0].wr;
                    Req_Lock[i]  = cq[i][0].lk;
                    Req_Address[WORD_W*i +: WORD_W]   = cq[i][0].addr;
                    Req_WriteData[WORD_W*i +: WORD_W] = cq[i][0].wdata;
                end else begin
                    Req[i] = 1'b0; Req_Write[i] = 1'b0; Req_Lock[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every grant pops the scoreboard; a load grant makes a response due next cycle
    initial begin
        iss_t e;
        forever begin
            @(negedge Clk);
            ack_seen = Ack;
            if (!Rst_n) begin
                due = 1'b0;
            end else begin
                if (due) begin
                    chk("rsp_valid", 32'(Rsp_Valid), 32'(1) << due_core);
                    chk("rsp_rdata", Rsp_ReadData, due_data);
                end else if (Rsp_Valid != '0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_rsp: got %b expected 0000 at %0t", Rsp_Valid, $time);
                end
                due = 1'b0;
                if (Ack != '0) begin
                    if (exp_iss.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_ack: got %b expected 0000 at %0t", Ack, $time);
                    end else begin
                        e = exp_iss.pop_front();
                        chk("ack", 32'(Ack), 32'(1) << e.core);
                        chk("grant_idx", 32'(Grant_Idx), 32'(e.core));
                        chk("mem_addr", Mem_Address, e.addr);
                        chk("mem_write", 32'(Mem_MemWrite), 32'(e.wr));
                        chk("mem_read", 32'(Mem_MemRead), 32'(!e.wr));
                        if (e.wr) begin
                            chk("mem_wdata", Mem_WriteData, e.wdata);
                        end else begin
                            due = 1'b1; due_core = e.core; due_data = e.rdata;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach the summary, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("rst_ack", 32'(Ack), 32'h0);
        chk("rst_rsp_valid", 32'(Rsp_Valid), 32'h0);
        chk("rst_rsp_rdata", Rsp_ReadData, 32'h0);
        chk("rst_mem_addr", Mem_Address, 32'h0);
        chk("rst_grant_idx", 32'(Grant_Idx), 32'h0);
        chk("rst_mem_rd_wr", 32'({Mem_MemRead, Mem_MemWrite}), 32'h0);
        @(posedge Clk); #2 Rst_n = 1'b1;
        @(negedge Clk);

        // Single load from core 0
        push_txn(0, 1'b0, 1'b0, 32'h10, 32'h0);
        exp_i(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        wait_drain();

        // Fresh reset, all four cores loading back-to-back: 0,1,2,3,0,1,2,3
        Rst_n = 1'b0;
        @(posedge Clk); #2 Rst_n = 1'b1;
        @(negedge Clk);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NC; i++) begin
                a = 32'h100 + 32'(16 * j + 4 * i);
                push_txn(i, 1'b0, 1'b0, a, 32'h0);
                exp_i(i, 1'b0, a, 32'h0, init_word(32'h40 + 4 * j + i));
            end
        end
        wait_drain();

        // Core 2 locks for MAX_LOCK grants, then forced release lets core 0 in
        for (int j = 0; j < 5; j++) push_txn(2, 1'b0, 1'b1, 32'h300 + 32'(4 * j), 32'h0);
        for (int j = 0; j < 4; j++) exp_i(2, 1'b0, 32'h300 + 32'(4 * j), 32'h0, init_word(32'hC0 + j));
        exp_i(0, 1'b0, 32'h40, 32'h0, init_word(32'h10));
        exp_i(1, 1'b0, 32'h80, 32'h0, init_word(32'h20));
        exp_i(2, 1'b0, 32'h310, 32'h0, init_word(32'hC4));
        @(negedge Clk);
        push_txn(0, 1'b0, 1'b0, 32'h40, 32'h0);
        push_txn(1, 1'b0, 1'b0, 32'h80, 32'h0);
        wait_drain();

        // Store from core 1 followed by a load of the same word from core 3
        push_txn(1, 1'b1, 1'b0, 32'h20, 32'h1234_5678);
        exp_i(1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
        exp_i(3, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
        @(negedge Clk);
        push_txn(3, 1'b0, 1'b0, 32'h20, 32'h0);
        wait_drain();

        // Reset in the cycle after a load grant drops the response and the pointer
        push_txn(0, 1'b0, 1'b0, 32'h10, 32'h0);
        exp_i(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        @(negedge Clk);
        push_txn(3, 1'b1, 1'b0, 32'h44, 32'hCAFE_F00D);
        push_txn(0, 1'b0, 1'b0, 32'h10, 32'h0);
        exp_i(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        exp_i(3, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h0);
        @(posedge Clk); #2 Rst_n = 1'b0;
        @(negedge Clk);
        chk("midrst_ack", 32'(Ack), 32'h0);
        chk("midrst_mem_write", 32'(Mem_MemWrite), 32'h0);
        chk("midrst_mem_read", 32'(Mem_MemRead), 32'h0);
        chk("midrst_rsp_valid", 32'(Rsp_Valid), 32'h0);
        chk("midrst_rsp_rdata", Rsp_ReadData, 32'h0);
        chk("midrst_mem_addr", Mem_Address, 32'h0);
        @(posedge Clk); #2 Rst_n = 1'b1;
        wait_drain();

        // Idle: nothing issued, last address and last load data held
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            chk("idle_ack", 32'(Ack), 32'h0);
            chk("idle_mem_rd_wr", 32'({Mem_MemRead, Mem_MemWrite}), 32'h0);
            chk("idle_rsp_valid", 32'(Rsp_Valid), 32'h0);
            chk("idle_rsp_rdata", Rsp_ReadData, 32'hDEAD_BEEF);
            chk("idle_mem_addr", Mem_Address, 32'h44);
            chk("idle_grant_idx", 32'(Grant_Idx), 32'h3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares port A of the data memory (32-bit word BRAM, clocked on ~Clk, word address = byte address[11:2]) among NUM_CORES requesters (cores).
- Issues at most one access per cycle and returns registered read data to the winning core one cycle later.
- Supports a lock request so a core can perform back-to-back accesses (e.g. read-modify-write) without interleaving, bounded by MAX_LOCK.
- Sits between the core MEM stages and the data memory.

Parameters:
NUM_CORES, 4, number of requesters (2..8)
IDX_W, 2, width of core index, equals clog2(NUM_CORES)
MAX_LOCK, 4, max consecutive grants to a locking core before forced release (1..15)

Ports:
Clk  input  1  system clock; all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
Req  input  NUM_CORES  per-core access request, held until Ack
Req_Write  input  NUM_CORES  1 = store, 0 = load
Req_Lock  input  NUM_CORES  request to keep ownership after this access
Req_Address  input  NUM_CORES*32  byte addresses, core i at [32*i+31:32*i]
Req_WriteData  input  NUM_CORES*32  store data, same packing
Ack  output  NUM_CORES  one-hot; access of that core is issued this cycle
Rsp_Valid  output  NUM_CORES  one-hot, one cycle; load data for that core on Rsp_ReadData
Rsp_ReadData  output  32  registered load data
Mem_Address  output  32  to EX_MEM_Address of data memory
Mem_WriteData  output  32  to EX_MEM_WriteData
Mem_MemWrite  output  1  to EX_MEM_MemWrite
Mem_MemRead  output  1  to EX_MEM_MemRead
Mem_ReadData  input  32  from MEM_ReadData_A, valid before the next posedge of the issue cycle
Grant_Idx  output  IDX_W  index of the currently issued core (debug/perf)

Behaviour:
- Reset (Rst_n low, asynchronous): rr_ptr=0, lock_owner invalid, lock_cnt=0, Rsp_Valid=0, Rsp_ReadData=0. Ack=0, Mem_MemWrite=0 and Mem_MemRead=0 are forced combinationally while Rst_n is low. Mem_Address, Mem_WriteData and Grant_Idx = 0.
- Arbitration is combinational each cycle:
  - If lock_owner is valid, Req[lock_owner]=1 and lock_cnt<MAX_LOCK, then winner=lock_owner.
  - Otherwise the winner is the first requesting core searching from rr_ptr upward, modulo NUM_CORES (wrap-around).
  - No Req asserted: Ack=0, Mem_MemRead=Mem_MemWrite=0, Mem_Address holds the last value (no glitching toggles needed).
- Issue:
  - Ack[winner]=1.
  - Mem_Address, Mem_WriteData, Mem_MemWrite=Req_Write[w] and Mem_MemRead=~Req_Write[w] are muxed from the winner in the same cycle.
  - The core drops or changes Req after sampling Ack at posedge.
- Posedge after an issue:
  - rr_ptr <= winner+1, wrapping to 0 after NUM_CORES-1.
  - If Req_Lock[winner]=1: lock_owner <= winner, and lock_cnt <= lock_cnt+1 if the winner was already the owner, else lock_cnt <= 1.
  - If Req_Lock[winner]=0: lock_owner invalid, lock_cnt <= 0.
- Forced release:
  - When lock_cnt==MAX_LOCK, the owner is excluded for one arbitration.
  - If another core requests it wins; lock_owner is cleared and lock_cnt <= 0.
  - If no other core requests, the owner may win again normally with lock_cnt restarting at 1.
- Lock owner deasserts Req: lock is released immediately (same cycle falls to round-robin) and state clears at posedge.
- Response:
  - For a load issued in cycle t: Rsp_ReadData <= Mem_ReadData and Rsp_Valid[winner] <= 1 at end of t, visible in cycle t+1 for exactly one cycle.
  - Stores produce no Rsp_Valid.
  - Latency: Ack same cycle, load data 1 cycle after Ack.
  - Throughput: one access per cycle, sustained.
- Simultaneous events: back-to-back loads from different cores give Rsp_Valid a different one-hot each cycle. Rsp_ReadData is held when no load was issued.
- Reset mid-operation: a pending response is discarded (Rsp_Valid cleared) and the lock is released.
- Out-of-range address bits above [11:2] are passed through unchanged; the memory ignores them.

Decomposition:
- Shared package dmem_pkg holds DMEM_ADDR_LSB=2, DMEM_ADDR_MSB=11, WORD_W=32 and the default NUM_CORES.
- One sub-module, rr_pick: combinational rotate-priority encoder with inputs req vector, start pointer and exclude mask; outputs winner index and valid. It is instantiated once.

Test Plan:
- Single core 0 load of addr 0x10 (memory preloaded 0xDEADBEEF) -> Ack[0] in cycle t, Mem_MemRead=1, Mem_Address=0x10; Rsp_Valid=0001 and Rsp_ReadData=0xDEADBEEF in t+1.
- All 4 cores request continuously with no lock, from reset -> Ack sequence 0,1,2,3,0 on consecutive cycles; each load's Rsp_Valid follows one cycle later.
- Core 2 holds Req_Lock with cores 0 and 1 requesting, MAX_LOCK=4 -> Ack[2] on 4 consecutive cycles, then Ack[3]? no: core 0 (next after rr_ptr=3 wraps) wins on cycle 5, and the lock clears.
- Core 1 store 0x12345678 to 0x20, then core 3 load of 0x20 next cycle -> Mem_MemWrite=1 then Mem_MemRead=1; Rsp_ReadData=0x12345678 with Rsp_Valid=1000.
- Assert Rst_n low in the cycle after a load Ack -> Rsp_Valid stays 0, Ack/Mem_MemWrite drop immediately; after release the first request from core 0 wins (rr_ptr=0).
- No requests for 10 cycles -> Ack=0, Mem_MemRead=Mem_MemWrite=0, Rsp_Valid=0, Rsp_ReadData unchanged.
